// File: rtl/uart_reg_arb_pkg.sv
// Shared types and defaults for the UART register-bus arbiter.
//   state_t     : sequencer states (IDLE, BUSY, GAP)
//   reg_req_t   : one latched downstream register transfer
package uart_reg_arb_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned TMO_W  = 8;

    localparam int unsigned TMO_CYC_DEF   = 255;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } reg_req_t;

endpackage

// File: rtl/uart_reg_arb_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr,
// wrapping past NREQ-1 back to 0.
//   req   : per-requester request vector
//   ptr   : starting index for the search
//   valid : at least one request present
//   idx   : winning requester index (0 when valid is low)
module rr_pick #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    // One extra bit so ptr+k never overflows before the explicit wrap.
    logic [ID_W:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!valid && req[j] && (cand == (ID_W+1)'(j))) begin
                    valid = 1'b1;
                    idx   = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_reg_arb.sv
// Round-robin arbiter/sequencer sharing the UART register bus between NREQ
// requesters. One transfer at a time, one forced idle cycle after each
// completion, and a no-ack timeout that completes with m_err.
//   app_clk, reset          : clock, synchronous active-high reset
//   m_cs/m_wr/m_addr/m_wdata/m_be : per-requester request (packed slices)
//   m_rdata/m_ack/m_err     : per-requester completion (registered pulses)
//   reg_cs/reg_wr/reg_addr/reg_wdata/reg_be : downstream request (registered)
//   reg_rdata/reg_ack       : downstream response
//   gnt_id                  : current/last granted requester
module uart_reg_arb
    import uart_reg_arb_pkg::*;
#(
    parameter  int unsigned NREQ      = 2,
    parameter  int unsigned TMO_CYC   = TMO_CYC_DEF,
    parameter  logic [31:0] ERR_RDATA = ERR_RDATA_DEF,
    localparam int unsigned ID_W      = $clog2(NREQ)
) (
    input  logic                     app_clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          m_cs,
    input  logic [NREQ-1:0]          m_wr,
    input  logic [NREQ*ADDR_W-1:0]   m_addr,
    input  logic [NREQ*DATA_W-1:0]   m_wdata,
    input  logic [NREQ*BE_W-1:0]     m_be,
    output logic [NREQ*DATA_W-1:0]   m_rdata,
    output logic [NREQ-1:0]          m_ack,
    output logic [NREQ-1:0]          m_err,
    output logic                     reg_cs,
    output logic                     reg_wr,
    output logic [ADDR_W-1:0]        reg_addr,
    output logic [DATA_W-1:0]        reg_wdata,
    output logic [BE_W-1:0]          reg_be,
    input  logic [DATA_W-1:0]        reg_rdata,
    input  logic                     reg_ack,
    output logic [ID_W-1:0]          gnt_id
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]     gnt_id_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
    reg_req_t            req_q, req_nxt, pick_req;
    logic                reg_cs_nxt;
    logic [NREQ-1:0]     m_ack_nxt, m_err_nxt;
    logic [NREQ*DATA_W-1:0] m_rdata_nxt;

    logic                pick_valid;
    logic [ID_W-1:0]     pick_idx;
    logic                tmo_hit;
    logic                done;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (m_cs),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYC - 1));
    // reg_ack has priority over the timeout when both land in the same cycle.
    assign done    = reg_ack || tmo_hit;

    // Mux the winning requester's fields.
    always_comb begin
        pick_req = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_req.wr    = m_wr[i];
                pick_req.addr  = m_addr[ADDR_W*i +: ADDR_W];
                pick_req.wdata = m_wdata[DATA_W*i +: DATA_W];
                pick_req.be    = m_be[BE_W*i +: BE_W];
            end
        end
    end

    // State register.
    always_ff @(posedge app_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = BUSY;
            BUSY:    if (done)       state_nxt = GAP;
            GAP:                     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values; ack/err are single-cycle pulses.
    always_comb begin
        req_nxt     = req_q;
        reg_cs_nxt  = reg_cs;
        gnt_id_nxt  = gnt_id;
        rr_ptr_nxt  = rr_ptr;
        tmo_cnt_nxt = tmo_cnt;
        m_ack_nxt   = '0;
        m_err_nxt   = '0;
        m_rdata_nxt = m_rdata;
        case (state)
            IDLE: begin
                reg_cs_nxt = 1'b0;
                if (pick_valid) begin
                    req_nxt     = pick_req;
                    reg_cs_nxt  = 1'b1;
                    gnt_id_nxt  = pick_idx;
                    tmo_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    reg_cs_nxt = 1'b0;
                    rr_ptr_nxt = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (gnt_id == ID_W'(i)) begin
                            m_ack_nxt[i] = 1'b1;
                            m_err_nxt[i] = !reg_ack;
                            if (!req_q.wr) begin
                                m_rdata_nxt[DATA_W*i +: DATA_W] = reg_ack ? reg_rdata : ERR_RDATA;
                            end
                        end
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            GAP: begin
                reg_cs_nxt = 1'b0;
            end
            default: begin
                reg_cs_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge app_clk) begin
        if (reset) begin
            req_q   <= '0;
            reg_cs  <= 1'b0;
            gnt_id  <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
            m_ack   <= '0;
            m_err   <= '0;
            m_rdata <= '0;
        end else begin
            req_q   <= req_nxt;
            reg_cs  <= reg_cs_nxt;
            gnt_id  <= gnt_id_nxt;
            rr_ptr  <= rr_ptr_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            m_ack   <= m_ack_nxt;
            m_err   <= m_err_nxt;
            m_rdata <= m_rdata_nxt;
        end
    end

    assign reg_wr    = req_q.wr;
    assign reg_addr  = req_q.addr;
    assign reg_wdata = req_q.wdata;
    assign reg_be    = req_q.be;

endmodule

// File: tb/tb_uart_reg_arb.sv
// Scoreboard bench for uart_reg_arb (NREQ=2, TMO_CYC=4).
// Stimulus pushes expected downstream requests and expected completions into
// queues; a slave model and a completion monitor pop and compare.
module tb_uart_reg_arb;

    localparam int TMO = 4;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        app_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [1:0]  m_cs    = '0;
    logic [1:0]  m_wr    = '0;
    logic [21:0] m_addr  = '0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_be    = '0;
    logic [63:0] m_rdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic        reg_cs;
    logic        reg_wr;
    logic [10:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack   = 1'b0;
    logic [0:0]  gnt_id;

    uart_reg_arb #(.NREQ(2), .TMO_CYC(TMO), .ERR_RDATA(ERR)) dut (
        .app_clk   (app_clk),
        .reset     (reset),
        .m_cs      (m_cs),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .gnt_id    (gnt_id)
    );

    always #5 app_clk = ~app_clk;

    typedef struct {
        int          id;
        bit          wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;       // reg_cs cycles before slave acks; 0 = never
        logic [31:0] rdata;
        int          exp_len;   // expected reg_cs high cycles; 0 = unchecked
        int          exp_gap;   // expected reg_cs low cycles before; 0 = unchecked
        int          exp_delay; // expected m_cs->reg_cs cycles; 0 = unchecked
    } txn_t;

    typedef struct {
        int          id;
        bit          err;
        bit          wr;
        logic [31:0] rdata;
    } cmp_t;

    txn_t rq0[$];
    txn_t rq1[$];
    txn_t exp_req[$];
    cmp_t exp_cmp[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_ack_cyc = 0;
    int   rise_cyc[2];
    bit   act[2];
    bit   abort_req   = 1'b0;
    bit   manual_mode = 1'b0;
    bit   manual_ack  = 1'b0;
    logic [31:0] exp_rd[2];

    always @(posedge app_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    task automatic issue(input int id, input bit wr, input logic [10:0] addr,
                         input logic [31:0] wd, input int lat, input logic [31:0] rd,
                         input int gap, input int delay, input bit cmp);
        txn_t t;
        cmp_t c;
        t.id = id; t.wr = wr; t.addr = addr; t.wdata = wd;
        t.be = wr ? 4'b0110 : 4'b1111;
        t.lat = lat; t.rdata = rd;
        t.exp_len = !cmp ? 0 : (lat == 0 ? TMO : lat);
        t.exp_gap = gap; t.exp_delay = delay;
        if (id == 0) rq0.push_back(t); else rq1.push_back(t);
        exp_req.push_back(t);
        if (cmp) begin
            c.id = id; c.wr = wr; c.err = (lat == 0);
            c.rdata = (lat == 0) ? ERR : rd;
            exp_cmp.push_back(c);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || act[0] || act[1] ||
                exp_cmp.size() != 0 || exp_req.size() != 0) && n < 300) begin
            @(negedge app_clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: queues not drained after %0d cycles", name, n);
        end
        repeat (3) @(negedge app_clk);
    endtask

    // Requester model: raise a queued request, hold it until m_ack, then drop.
    initial begin : requesters
        txn_t t;
        act[0] = 1'b0;
        act[1] = 1'b0;
        forever begin
            @(negedge app_clk);
            for (int i = 0; i < 2; i++) begin
                if (act[i] && (m_ack[i] || abort_req)) begin
                    act[i]  = 1'b0;
                    m_cs[i] = 1'b0;
                end else if (!act[i] && !abort_req &&
                             ((i == 0 && rq0.size() != 0) || (i == 1 && rq1.size() != 0))) begin
                    if (i == 0) t = rq0.pop_front(); else t = rq1.pop_front();
                    act[i]  = 1'b1;
                    m_cs[i] = 1'b1;
                    m_wr[i] = t.wr;
                    m_addr[11*i +: 11]  = t.addr;
                    m_wdata[32*i +: 32] = t.wdata;
                    m_be[4*i +: 4]      = t.be;
                    rise_cyc[i] = cyc;
                end
            end
        end
    end

    // Slave model: checks each downstream request against the expected order.
    txn_t cur;
    bit   have = 1'b0;
    bit   prev_cs = 1'b0;
    int   hi_cnt = 0;
    int   lo_cnt = 100;
    initial begin : slave
        forever begin
            @(negedge app_clk);
            if (reg_cs && !prev_cs) begin
                hi_cnt = 1;
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_reg_cs: got reg_cs=1 with addr %0h, required no request", reg_addr);
                end else begin
                    cur  = exp_req.pop_front();
                    have = 1'b1;
                    check("gnt_id", 64'(gnt_id), 64'(cur.id));
                    check("reg_wr", 64'(reg_wr), 64'(cur.wr));
                    check("reg_addr", 64'(reg_addr), 64'(cur.addr));
                    check("reg_wdata", 64'(reg_wdata), 64'(cur.wdata));
                    check("reg_be", 64'(reg_be), 64'(cur.be));
                    if (cur.exp_gap > 0) check("reg_cs_gap", 64'(lo_cnt), 64'(cur.exp_gap));
                    if (cur.exp_delay > 0) check("cs_latency", 64'(cyc - rise_cyc[cur.id]), 64'(cur.exp_delay));
                end
            end else if (reg_cs) begin
                hi_cnt++;
            end
            if (!reg_cs && prev_cs) begin
                if (have && cur.exp_len > 0) check("reg_cs_len", 64'(hi_cnt), 64'(cur.exp_len));
                have = 1'b0;
            end
            lo_cnt = reg_cs ? 0 : lo_cnt + 1;
            if (manual_mode) begin
                reg_ack   = manual_ack;
                reg_rdata = 32'hDEAD_BEEF;
            end else if (reg_cs && have && cur.lat > 0 && hi_cnt == cur.lat) begin
                reg_ack      = 1'b1;
                reg_rdata    = cur.rdata;
                last_ack_cyc = cyc;
            end else begin
                reg_ack   = 1'b0;
                reg_rdata = 32'h0;
            end
            prev_cs = reg_cs;
        end
    end

    // Completion monitor.
    initial begin : monitor
        cmp_t c;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        forever begin
            @(negedge app_clk);
            if (reset) begin
                exp_rd[0] = '0;
                exp_rd[1] = '0;
            end
            if (m_ack != 2'b00 || m_err != 2'b00) begin
                if (exp_cmp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_ack: got m_ack=%b m_err=%b, required none", m_ack, m_err);
                end else begin
                    c = exp_cmp.pop_front();
                    check("m_ack", 64'(m_ack), 64'(2'b01 << c.id));
                    check("m_err", 64'(m_err), c.err ? 64'(2'b01 << c.id) : 64'd0);
                    if (!c.wr) exp_rd[c.id] = c.rdata;
                    check("m_rdata", m_rdata, {exp_rd[1], exp_rd[0]});
                    if (!c.err) check("ack_latency", 64'(cyc - last_ack_cyc), 64'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        repeat (3) @(negedge app_clk);
        check("rst_reg_cs", 64'(reg_cs), 64'd0);
        check("rst_m_ack", 64'(m_ack), 64'd0);
        check("rst_m_err", 64'(m_err), 64'd0);
        check("rst_m_rdata", m_rdata, 64'd0);
        check("rst_gnt_id", 64'(gnt_id), 64'd0);
        check("rst_reg_addr", 64'(reg_addr), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge app_clk);

        // Single read, slave acks after 2 reg_cs cycles.
        issue(0, 1'b0, 11'h048, 32'h0, 2, 32'h0000_00A5, 0, 1, 1'b1);
        wait_idle("single_read");
        // Single write from requester 1 (brings rr_ptr back to 0).
        issue(1, 1'b1, 11'h0C4, 32'hCAFE_0001, 1, 32'h0, 0, 1, 1'b1);
        wait_idle("single_write");

        // Contention: grant 0 then 1 with GAP+IDLE between, then again 0,1.
        issue(0, 1'b1, 11'h010, 32'h1111_2222, 1, 32'h0, 0, 0, 1'b1);
        issue(1, 1'b0, 11'h7FF, 32'h0, 3, 32'h0BAD_F00D, 2, 0, 1'b1);
        wait_idle("contention1");
        issue(0, 1'b0, 11'h020, 32'h0, 1, 32'h1234_5678, 0, 0, 1'b1);
        issue(1, 1'b1, 11'h021, 32'h5555_AAAA, 1, 32'h0, 2, 0, 1'b1);
        wait_idle("contention2");

        // Fairness: strict alternation over 8 transfers.
        for (int k = 0; k < 4; k++) begin
            issue(0, 1'b0, 11'(11'h100 + k), 32'h0, 1, 32'hA000_0000 + 32'(k), 0, 0, 1'b1);
            issue(1, 1'b0, 11'(11'h180 + k), 32'h0, 1, 32'hB000_0000 + 32'(k), 2, 0, 1'b1);
        end
        wait_idle("fairness");

        // Timeout (slave silent), then a normal back-to-back transfer.
        issue(0, 1'b0, 11'h200, 32'h0, 0, 32'h0, 0, 1, 1'b1);
        issue(0, 1'b0, 11'h201, 32'h0, 2, 32'h0000_5A5A, 2, 0, 1'b1);
        wait_idle("timeout");

        // Ack lands in the same cycle the timeout would fire.
        issue(1, 1'b0, 11'h202, 32'h0, TMO, 32'hC0FF_EE00, 0, 1, 1'b1);
        wait_idle("collision");

        // Make rr_ptr non-zero, then reset in the middle of a transfer.
        issue(0, 1'b1, 11'h300, 32'h0000_0300, 1, 32'h0, 0, 1, 1'b1);
        wait_idle("pre_reset");
        issue(1, 1'b0, 11'h301, 32'h0, 0, 32'h0, 0, 1, 1'b0);
        n = 0;
        while (!reg_cs && n < 20) begin
            @(negedge app_clk);
            n++;
        end
        check("busy_before_reset", 64'(reg_cs), 64'd1);
        @(negedge app_clk);
        reset     = 1'b1;
        abort_req = 1'b1;
        @(negedge app_clk);
        check("rst_mid_reg_cs", 64'(reg_cs), 64'd0);
        check("rst_mid_m_ack", 64'(m_ack), 64'd0);
        check("rst_mid_m_err", 64'(m_err), 64'd0);
        check("rst_mid_gnt_id", 64'(gnt_id), 64'd0);
        check("rst_mid_m_rdata", m_rdata, 64'd0);
        @(negedge app_clk);
        reset       = 1'b0;
        manual_mode = 1'b1;
        manual_ack  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge app_clk);
            check("late_ack_ignored", 64'(m_ack), 64'd0);
        end
        manual_ack  = 1'b0;
        @(negedge app_clk);
        manual_mode = 1'b0;
        abort_req   = 1'b0;
        repeat (2) @(negedge app_clk);

        // rr_ptr cleared by reset: simultaneous requests grant 0 first.
        issue(0, 1'b0, 11'h010, 32'h0, 1, 32'h0000_1111, 0, 0, 1'b1);
        issue(1, 1'b0, 11'h011, 32'h0, 1, 32'h0000_2222, 2, 0, 1'b1);
        wait_idle("post_reset");

        check("exp_req_drained", 64'(exp_req.size()), 64'd0);
        check("exp_cmp_drained", 64'(exp_cmp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
